// File: rtl/decode_stage.sv
// decode_stage: MIPS ID stage (IF/ID latch, register file, sign extension, control decode, ID/EX register)
// Ports: clk/rst_n (async active-low); if_instr/if_npc from fetch; stall/flush hazard controls;
//        wb_regwrite/wb_rd/wb_data write-back port; id_* registered ID/EX outputs, id_valid marks real instructions.
// Option: define WB_BYPASS_EN to forward same-cycle write-back data onto rs/rt reads.
module decode_stage #(
   parameter int              DATA_W    = 32,
   parameter int              REG_COUNT = 32,
   parameter logic [DATA_W-1:0] RESET_NPC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] if_instr,
   input  logic [DATA_W-1:0] if_npc,
   input  logic              stall,
   input  logic              flush,
   input  logic              wb_regwrite,
   input  logic [4:0]        wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] id_npc,
   output logic [DATA_W-1:0] id_rs_data,
   output logic [DATA_W-1:0] id_rt_data,
   output logic [DATA_W-1:0] id_imm,
   output logic [4:0]        id_rt,
   output logic [4:0]        id_rd,
   output logic [1:0]        id_ctl_wb,
   output logic [2:0]        id_ctl_m,
   output logic [3:0]        id_ctl_ex,
   output logic              id_valid
);
   logic [DATA_W-1:0] ifid_instr, ifid_npc;
   logic [DATA_W-1:0] regs [REG_COUNT];
   logic [DATA_W-1:0] rs_data, rt_data;
   logic [4:0]        rs, rt;
   logic              wb_we, valid;
   logic [1:0]        ctl_wb;
   logic [2:0]        ctl_m;
   logic [3:0]        ctl_ex;
   assign rs    = ifid_instr[25:21];
   assign rt    = ifid_instr[20:16];
   assign wb_we = wb_regwrite && wb_rd != 5'd0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifid_instr <= '0;
         ifid_npc   <= RESET_NPC;
      end else if (flush) begin
         ifid_instr <= '0;
         ifid_npc   <= RESET_NPC;
      end else if (!stall) begin
         ifid_instr <= if_instr;
         ifid_npc   <= if_npc;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      else if (wb_we)
         regs[wb_rd] <= wb_data;
   end
   always_comb begin
`ifdef WB_BYPASS_EN
      rs_data = rs == 5'd0 ? '0 : (wb_we && wb_rd == rs) ? wb_data : regs[rs];
      rt_data = rt == 5'd0 ? '0 : (wb_we && wb_rd == rt) ? wb_data : regs[rt];
`else
      rs_data = rs == 5'd0 ? '0 : regs[rs];
      rt_data = rt == 5'd0 ? '0 : regs[rt];
`endif
   end
   // an all-zero instruction is a bubble; unknown opcodes are real nops
   always_comb begin
      valid  = ifid_instr != '0;
      ctl_ex = 4'b0000;
      ctl_m  = 3'b000;
      ctl_wb = 2'b00;
      case (ifid_instr[31:26])
         6'h00: if (valid) {ctl_ex, ctl_m, ctl_wb} = {4'b1100, 3'b000, 2'b10};
         6'h23: {ctl_ex, ctl_m, ctl_wb} = {4'b0001, 3'b010, 2'b11};
         6'h2B: {ctl_ex, ctl_m, ctl_wb} = {4'b0001, 3'b001, 2'b00};
         6'h04: {ctl_ex, ctl_m, ctl_wb} = {4'b0010, 3'b100, 2'b00};
         default: ;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_npc     <= RESET_NPC;
         id_rs_data <= '0;
         id_rt_data <= '0;
         id_imm     <= '0;
         id_rt      <= '0;
         id_rd      <= '0;
         id_ctl_wb  <= '0;
         id_ctl_m   <= '0;
         id_ctl_ex  <= '0;
         id_valid   <= 1'b0;
      end else begin
         id_npc     <= ifid_npc;
         id_rs_data <= rs_data;
         id_rt_data <= rt_data;
         id_imm     <= {{(DATA_W-16){ifid_instr[15]}}, ifid_instr[15:0]};
         id_rt      <= ifid_instr[20:16];
         id_rd      <= ifid_instr[15:11];
         id_ctl_wb  <= stall ? 2'b00 : ctl_wb;
         id_ctl_m   <= stall ? 3'b000 : ctl_m;
         id_ctl_ex  <= stall ? 4'b0000 : ctl_ex;
         id_valid   <= !stall && valid;
      end
   end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized and directed checks of decode_stage against a behavioural model
module tb_decode_stage;
   logic        clk = 1'b0, rst_n = 1'b1;
   logic [31:0] if_instr = '0, if_npc = '0, wb_data = '0;
   logic        stall = 1'b0, flush = 1'b0, wb_regwrite = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] id_npc, id_rs_data, id_rt_data, id_imm;
   logic [4:0]  id_rt, id_rd;
   logic [1:0]  id_ctl_wb;
   logic [2:0]  id_ctl_m;
   logic [3:0]  id_ctl_ex;
   logic        id_valid;
   int checks = 0, errors = 0;
   logic [31:0] m_regs [32];
   logic [31:0] m_instr, m_npc;
   logic [31:0] e_npc, e_rs, e_rt, e_imm;
   logic [4:0]  e_rti, e_rdi;
   logic [1:0]  e_wb;
   logic [2:0]  e_m;
   logic [3:0]  e_ex;
   logic        e_valid;
   decode_stage dut (
      .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .if_npc(if_npc),
      .stall(stall), .flush(flush), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
      .id_npc(id_npc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_rt(id_rt), .id_rd(id_rd), .id_ctl_wb(id_ctl_wb), .id_ctl_m(id_ctl_m),
      .id_ctl_ex(id_ctl_ex), .id_valid(id_valid)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   // {valid, ex[3:0], m[2:0], wb[1:0]} looked up from the opcode table
   function automatic logic [9:0] ctl_of(input logic [31:0] ins);
      if (ins == 32'h0) return 10'b0;
      case (ins[31:26])
         6'h00:   return 10'b1_1100_000_10;
         6'h23:   return 10'b1_0001_010_11;
         6'h2B:   return 10'b1_0001_001_00;
         6'h04:   return 10'b1_0010_100_00;
         default: return 10'b1_0000_000_00;
      endcase
   endfunction
   function automatic logic [31:0] read_reg(input logic [4:0] idx);
`ifdef WB_BYPASS_EN
      if (wb_regwrite && wb_rd != 0 && wb_rd == idx) return wb_data;
`endif
      return idx == 0 ? 32'h0 : m_regs[idx];
   endfunction
   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_instr = '0; m_npc = '0;
      e_npc = '0; e_rs = '0; e_rt = '0; e_imm = '0; e_rti = '0; e_rdi = '0;
      e_wb = '0; e_m = '0; e_ex = '0; e_valid = 1'b0;
   endtask
   task automatic model_edge();
      logic [9:0] c;
      int t;
      c = stall ? 10'b0 : ctl_of(m_instr);
      {e_valid, e_ex, e_m, e_wb} = c;
      e_npc = m_npc;
      e_rs  = read_reg(m_instr[25:21]);
      e_rt  = read_reg(m_instr[20:16]);
      t = int'(m_instr[15:0]);
      if (m_instr[15]) t -= 65536;
      e_imm = t;
      e_rti = m_instr[20:16];
      e_rdi = m_instr[15:11];
      if (flush) begin
         m_instr = '0; m_npc = '0;
      end else if (!stall) begin
         m_instr = if_instr; m_npc = if_npc;
      end
      if (wb_regwrite && wb_rd != 0) m_regs[wb_rd] = wb_data;
   endtask
   task automatic compare_all();
      check("npc", id_npc, e_npc);
      check("rs_data", id_rs_data, e_rs);
      check("rt_data", id_rt_data, e_rt);
      check("imm", id_imm, e_imm);
      check("rt", 32'(id_rt), 32'(e_rti));
      check("rd", 32'(id_rd), 32'(e_rdi));
      check("ctl_wb", 32'(id_ctl_wb), 32'(e_wb));
      check("ctl_m", 32'(id_ctl_m), 32'(e_m));
      check("ctl_ex", 32'(id_ctl_ex), 32'(e_ex));
      check("valid", 32'(id_valid), 32'(e_valid));
   endtask
   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask
   task automatic drive(input logic [31:0] ins, input logic [31:0] npc, input logic st, input logic fl,
                        input logic we, input logic [4:0] rd, input logic [31:0] data);
      if_instr = ins; if_npc = npc; stall = st; flush = fl;
      wb_regwrite = we; wb_rd = rd; wb_data = data;
   endtask
   task automatic rand_drive();
      logic [31:0] r, ins;
      logic [5:0]  op;
      logic [4:0]  rd;
      r  = $urandom();
      op = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 5))
         0: op = 6'h00;
         1: op = 6'h23;
         2: op = 6'h2B;
         3: op = 6'h04;
         default: ;
      endcase
      ins = {op, r[25:0]};
      if ($urandom_range(0, 5) == 0) ins = '0;
      rd = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) rd = m_instr[25:21];
      else if ($urandom_range(0, 2) == 0) rd = m_instr[20:16];
      drive(ins, $urandom(), $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
            1'($urandom_range(0, 1)), rd, $urandom());
   endtask
   initial begin
      model_reset();
      #1 rst_n = 1'b0;
      #1 compare_all();
      @(negedge clk) rst_n = 1'b1;
      // lw after writing $2
      drive(32'h0, 32'h0, 0, 0, 1, 5'd2, 32'h10); cyc();
      drive(32'h8C43FFFC, 32'd5, 0, 0, 0, 5'd0, 32'h0); cyc();
      drive(32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0); cyc();
      check("lw_npc", id_npc, 32'd5);
      check("lw_rs", id_rs_data, 32'h10);
      check("lw_imm", id_imm, 32'hFFFFFFFC);
      check("lw_rt", 32'(id_rt), 32'd3);
      check("lw_ctl", 32'({id_ctl_ex, id_ctl_m, id_ctl_wb, id_valid}), 32'b0001_010_11_1);
      // stall holds IF/ID and bubbles ID/EX
      drive(32'h00221820, 32'd7, 0, 0, 0, 5'd0, 32'h0); cyc();
      drive(32'h8C000000, 32'd8, 1, 0, 0, 5'd0, 32'h0); cyc();
      check("stall_ctl", 32'({id_ctl_ex, id_ctl_m, id_ctl_wb, id_valid}), 32'h0);
      drive(32'h0, 32'd9, 0, 0, 0, 5'd0, 32'h0); cyc();
      check("unstall_ctl", 32'({id_ctl_ex, id_ctl_m, id_ctl_wb, id_valid}), 32'b1100_000_10_1);
      check("unstall_npc", id_npc, 32'd7);
      // flush beats stall
      drive(32'h10220003, 32'd10, 0, 0, 0, 5'd0, 32'h0); cyc();
      drive(32'h8C430004, 32'd11, 1, 1, 0, 5'd0, 32'h0); cyc();
      check("fs_valid", 32'(id_valid), 32'h0);
      drive(32'h0, 32'd12, 0, 0, 0, 5'd0, 32'h0); cyc();
      check("flush_bubble", 32'({id_ctl_ex, id_ctl_m, id_ctl_wb, id_valid}), 32'h0);
      check("flush_npc", id_npc, 32'h0);
      // $0 write ignored
      drive(32'h0, 32'h0, 0, 0, 1, 5'd0, 32'hDEAD); cyc();
      drive(32'h00001820, 32'd13, 0, 0, 0, 5'd0, 32'h0); cyc();
      drive(32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0); cyc();
      check("r0_read", id_rs_data, 32'h0);
      // same-cycle write-back on rs
      drive(32'h00A00020, 32'd14, 0, 0, 0, 5'd0, 32'h0); cyc();
      drive(32'h0, 32'd15, 0, 0, 1, 5'd5, 32'h1234); cyc();
`ifdef WB_BYPASS_EN
      check("bypass_rs", id_rs_data, 32'h1234);
`else
      check("bypass_rs", id_rs_data, 32'h0);
`endif
      drive(32'h00A00020, 32'd16, 0, 0, 0, 5'd0, 32'h0); cyc();
      drive(32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0); cyc();
      check("late_rs", id_rs_data, 32'h1234);
      for (int i = 0; i < 300; i++) begin
         rand_drive();
         cyc();
      end
      // asynchronous reset in mid-cycle
      #3 rst_n = 1'b0;
      #1 model_reset();
      compare_all();
      @(negedge clk) rst_n = 1'b1;
      drive(32'h00A00020, 32'd20, 0, 0, 0, 5'd0, 32'h0); cyc();
      drive(32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0); cyc();
      check("post_reset_rs", id_rs_data, 32'h0);
      for (int i = 0; i < 200; i++) begin
         rand_drive();
         cyc();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
